// File: rtl/alu_defs.sv
`default_nettype none
// ============================================================================
// alu_defs : ALU operation codes and multiply-sequencer state encoding
// Revision : 1.0
// ============================================================================
package alu_defs;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b0100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// alu_mul_sequencer : unsigned WIDTHxWIDTH multiply by shift-and-add on the shared ALU
// Revision : 1.0
// ============================================================================
module alu_mul_sequencer
  import alu_defs::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  phi_q, phi_d;
  logic [WIDTH-1:0]  plo_q, plo_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              carry;

  // The ALU has no carry-out; an unsigned add wrapped iff the sum is below an addend.
  assign carry = (alu_out < phi_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_ITER) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == S_RUN);
    done          = (state_q == S_DONE);
    alu_operation = ALU_ADD;
    alu_in1       = '0;
    alu_in2       = '0;
    if (state_q == S_RUN) begin
      alu_in1 = phi_q;
      alu_in2 = plo_q[0] ? mcand_q : '0;
    end
  end

  always_comb begin
    mcand_d = mcand_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = op_a;
          phi_d   = '0;
          plo_d   = op_b;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        {phi_d, plo_d} = {carry, alu_out, plo_q[WIDTH-1:1]};
        cnt_d          = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product_hi = phi_q;
  assign product_lo = plo_q;

endmodule
`default_nettype wire

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that performs unsigned 32x32->64 multiplication by sequencing the shared combinational ALU through 32 shift-and-add iterations.
- Sits in the EX stage beside the ALU. It drives the ALU operand and operation inputs while busy, and the EX mux hands the ALU to it.
- Provides a start/busy/done handshake to the main control unit, which stalls the pipeline while busy.

Parameters:
- WIDTH, 32, operand width; must equal ALU data width.
- ITER_W, 6, iteration-counter width; must hold 0..WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request; accepted only when state is IDLE.
- op_a  input  WIDTH  multiplicand; captured at accept.
- op_b  input  WIDTH  multiplier; captured at accept.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when product is final.
- product_hi  output  WIDTH  upper half of result.
- product_lo  output  WIDTH  lower half of result.
- alu_in1  output  WIDTH  to ALU in1.
- alu_in2  output  WIDTH  to ALU in2.
- alu_operation  output  4  to ALU operation select.
- alu_out  input  WIDTH  from ALU result.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). No asynchronous logic.
- Reset (rst_n=0 at edge):
  - State goes to IDLE.
  - busy=0, done=0, product_hi=0, product_lo=0.
  - Internal multiplicand register and counter cleared.
  - Reset takes priority over all other events, including mid-RUN; a partial result is discarded.
- States: IDLE, RUN, DONE (registered, binary encoded).
- IDLE:
  - start=1 at edge: mcand<=op_a, product_hi<=0, product_lo<=op_b, cnt<=0, go RUN.
  - Otherwise hold; product registers retain the last result.
- RUN, one iteration per edge, no early exit:
  - alu_in1=product_hi.
  - alu_in2 = product_lo[0] ? mcand : 0.
  - alu_operation=4'b0010 (ADD).
  - carry = (alu_out < product_hi), unsigned compare; the ALU has no carry-out.
  - At edge: {product_hi, product_lo} <= {carry, alu_out, product_lo[WIDTH-1:1]}; cnt<=cnt+1.
  - When cnt==WIDTH-1 at edge, go DONE.
- DONE:
  - done=1 for exactly one cycle; product registers hold the final value.
  - Next edge goes to IDLE unconditionally.
- Latency: start accepted at edge T; iterations at edges T+1..T+32; done high between edges T+32 and T+33.
- busy and done are decoded from registered state: busy=(state==RUN), done=(state==DONE). They are never high together.
- start while RUN or DONE: ignored, no queuing. The requester re-asserts it in IDLE.
- op_a/op_b changes after accept have no effect.
- ALU outputs outside RUN: alu_in1=0, alu_in2=0, alu_operation=4'b0010. The EX mux ignores them when busy=0.
- Arithmetic is unsigned modulo 2^64; overflow is impossible by construction. ALU ZERO is not used.

Decomposition:
- Shared package/include alu_defs holds the ALU operation codes:
  - ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100, ALU_SLL=4'b0100.
- The state encoding localparams (S_IDLE, S_RUN, S_DONE) also go in alu_defs.
- No sub-module: a single FSM plus datapath registers. The bench instantiates the existing ALU and connects it to the alu_* ports.

Test Plan:
- Reset then op_a=3, op_b=5, start pulse -> busy=1 for 32 cycles, done pulse at T+32, product_hi=0, product_lo=15; product still 15 five cycles later.
- op_a=op_b=32'hFFFFFFFF -> product_hi=32'hFFFFFFFE, product_lo=32'h00000001 (exercises the carry path every iteration).
- op_a=32'h12345678, op_b=0 -> product 0 at done; op_a=0, op_b=32'hDEADBEEF -> product 0. Latency is still 32 cycles in both cases.
- start re-pulsed at iterations 5 and 31 and during DONE, with different operands -> ignored, first result unchanged, exactly one done pulse. start asserted the cycle after DONE -> accepted.
- rst_n=0 for one edge at iteration 10 of 7*9 -> next cycle busy=0, done=0, product 0, state IDLE. A new start of 7*9 then yields 63.
- Randomised back-to-back starts issued in IDLE (1000 pairs) -> {product_hi, product_lo} equals the 64-bit reference product, and alu_operation==ADD throughout RUN.
